// File: rtl/mtm_Alu_pkg.sv
// rtl/mtm_Alu_pkg.sv - shared types and constants for the ALU result serializer
package mtm_Alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_DATA,
    ST_STOP
  } state_e;

  localparam logic CMD_DATA = 1'b0;
  localparam logic CMD_CTL  = 1'b1;

  localparam int FRAME_LEN = 11;

  // err_flags bit positions: the three error kinds appear twice, high copy first
  localparam int ERR_DATA_A = 5;
  localparam int ERR_CRC_A  = 4;
  localparam int ERR_OP_A   = 3;
  localparam int ERR_DATA_B = 2;
  localparam int ERR_CRC_B  = 1;
  localparam int ERR_OP_B   = 0;

  // x^3 + x + 1 with the x^3 term implicit
  localparam logic [2:0] CRC3_POLY = 3'b011;

  localparam logic [2:0] RES_LAST_FRAME = 3'd4;

endpackage

// File: rtl/mtm_Alu_crc3.sv
// rtl/mtm_Alu_crc3.sv - combinational CRC3 over 37 bits, MSB first, zero init
module mtm_Alu_crc3
  import mtm_Alu_pkg::*;
(
  input  logic [36:0] data_i,
  output logic [2:0]  crc_o
);

  logic [2:0] crc_acc;

  always_comb begin
    crc_acc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      crc_acc = {crc_acc[1:0], 1'b0} ^ ((crc_acc[2] ^ data_i[i]) ? CRC3_POLY : 3'b000);
    end
  end

  assign crc_o = crc_acc;

endmodule

// File: rtl/mtm_alu_serializer.sv
// rtl/mtm_alu_serializer.sv - turns ALU results/errors into 11-bit serial frames
module mtm_alu_serializer
  import mtm_Alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic [3:0]  res_flags,
  input  logic        err_valid,
  input  logic [5:0]  err_flags,
  output logic        in_ready,
  output logic        sout
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 4);

  state_e      state_q;
  logic [2:0]  bit_q;
  logic [2:0]  frame_q;
  logic        is_err_q;
  logic [31:0] data_q;
  logic [3:0]  flags_q;
  logic [5:0]  eflags_q;
  logic        in_ready_q;
  logic        sout_q;

  logic [2:0]  crc;
  logic [7:0]  payload_d;
  logic        cmd_d;
  logic [2:0]  last_frame;
  logic [2:0]  next_idx;
  logic        accept;

  mtm_Alu_crc3 u_crc (
    .data_i ({data_q, 1'b0, flags_q}),
    .crc_o  (crc)
  );

  assign accept     = (res_valid | err_valid) & in_ready_q;
  assign last_frame = is_err_q ? 3'd0 : RES_LAST_FRAME;
  assign next_idx   = 3'd6 - bit_q;

  always_comb begin
    payload_d = 8'h00;
    cmd_d     = CMD_DATA;
    if (is_err_q) begin
      // trailing bit evens out the ones-count of the whole byte
      payload_d = {1'b1, eflags_q[ERR_DATA_A], eflags_q[ERR_CRC_A], eflags_q[ERR_OP_A],
                   eflags_q[ERR_DATA_B], eflags_q[ERR_CRC_B], eflags_q[ERR_OP_B], ~^eflags_q};
      cmd_d     = CMD_CTL;
    end else begin
      case (frame_q)
        3'd0:    payload_d = data_q[31:24];
        3'd1:    payload_d = data_q[23:16];
        3'd2:    payload_d = data_q[15:8];
        3'd3:    payload_d = data_q[7:0];
        default: begin
          payload_d = {1'b0, flags_q, crc};
          cmd_d     = CMD_CTL;
        end
      endcase
    end
  end

  // state_q names the bit currently driven on sout_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_q      <= 3'd0;
      frame_q    <= 3'd0;
      is_err_q   <= 1'b0;
      data_q     <= 32'd0;
      flags_q    <= 4'd0;
      eflags_q   <= 6'd0;
      in_ready_q <= 1'b1;
      sout_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_START;
            sout_q     <= 1'b0;
            in_ready_q <= 1'b0;
            bit_q      <= 3'd0;
            frame_q    <= 3'd0;
            is_err_q   <= err_valid;
            data_q     <= res_data;
            flags_q    <= res_flags;
            eflags_q   <= err_flags;
          end
        end
        ST_START: begin
          state_q <= ST_CMD;
          sout_q  <= cmd_d;
        end
        ST_CMD: begin
          state_q <= ST_DATA;
          sout_q  <= payload_d[7];
          bit_q   <= 3'd0;
        end
        ST_DATA: begin
          if (bit_q == LAST_BIT) begin
            state_q <= ST_STOP;
            sout_q  <= 1'b1;
            bit_q   <= 3'd0;
          end else begin
            bit_q  <= bit_q + 3'd1;
            sout_q <= payload_d[next_idx];
          end
        end
        ST_STOP: begin
          if (frame_q != last_frame) begin
            state_q <= ST_START;
            sout_q  <= 1'b0;
            frame_q <= frame_q + 3'd1;
          end else begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            frame_q    <= 3'd0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          sout_q     <= 1'b1;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign sout     = sout_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb/tb_mtm_alu_serializer.sv - self-checking bench with a bit-queue reference model
module tb_mtm_alu_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic        err_valid;
  logic [5:0]  err_flags;
  logic        in_ready;
  logic        sout;

  always #5 clk = ~clk;

  mtm_alu_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_flags (res_flags),
    .err_valid (err_valid),
    .err_flags (err_flags),
    .in_ready  (in_ready),
    .sout      (sout)
  );

  int vectors = 0;
  int miscompares = 0;

  bit   exp_q[$];
  logic exp_sout = 1'b1;
  logic exp_ready = 1'b1;
  bit   tr[$];
  bit   tr_rdy[$];

  function automatic logic [2:0] crc3_ref(input logic [36:0] msg);
    logic [39:0] v;
    v = {msg, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (v[i]) v = v ^ (40'b1011 << (i - 3));
    return v[2:0];
  endfunction

  function automatic logic [7:0] err_byte(input logic [5:0] e);
    logic [6:0] b;
    b = {1'b1, e};
    return {b, ($countones(b) % 2 == 1) ? 1'b1 : 1'b0};
  endfunction

  function automatic logic [7:0] ctl_byte(input logic [31:0] c, input logic [3:0] f);
    return {1'b0, f, crc3_ref({c, 1'b0, f})};
  endfunction

  task automatic push_frame(input bit ctl, input logic [7:0] b);
    exp_q.push_back(1'b0);
    exp_q.push_back(ctl);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    exp_q.push_back(1'b1);
  endtask

  // Model: a packet is a list of bits; busy while bits remain to be shifted out
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_sout  = 1'b1;
      exp_ready = 1'b1;
    end else begin
      if (exp_ready && (res_valid || err_valid)) begin
        if (err_valid) push_frame(1'b1, err_byte(err_flags));
        else begin
          for (int k = 3; k >= 0; k--) push_frame(1'b0, res_data[8*k +: 8]);
          push_frame(1'b1, ctl_byte(res_data, res_flags));
        end
      end
      if (exp_q.size() > 0) begin
        exp_sout  = exp_q.pop_front();
        exp_ready = 1'b0;
      end else begin
        exp_sout  = 1'b1;
        exp_ready = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("sout", {31'd0, sout}, {31'd0, exp_sout});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    tr.push_back(sout);
    tr_rdy.push_back(in_ready);
  endtask

  function automatic logic [7:0] tr_byte(input int base);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[7-j] = tr[base + 2 + j];
    return r;
  endfunction

  function automatic int low_count();
    int n = 0;
    foreach (tr_rdy[i]) if (!tr_rdy[i]) n++;
    return n;
  endfunction

  task automatic send(input bit rv, input bit ev, input logic [31:0] d, input logic [3:0] f,
                      input logic [5:0] e, input int n);
    res_valid = rv; err_valid = ev; res_data = d; res_flags = f; err_flags = e;
    tr.delete(); tr_rdy.delete();
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) begin
        res_valid = 1'b0; err_valid = 1'b0;
        res_data = $urandom; res_flags = 4'($urandom); err_flags = 6'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; err_valid = 1'b0;
    res_data = 32'd0; res_flags = 4'd0; err_flags = 6'd0;

    check("crc_ref_pin", {29'd0, crc3_ref({32'd0, 1'b0, 4'b0010})}, 32'h6);
    check("err_a5_pin", {24'd0, err_byte(6'b010010)}, 32'hA5);
    check("err_c9_pin", {24'd0, err_byte(6'b100100)}, 32'hC9);
    check("ctl_16_pin", {24'd0, ctl_byte(32'd0, 4'b0010)}, 32'h16);

    res_valid = 1'b1; err_valid = 1'b1;
    repeat (3) step();
    check("reset_sout", {31'd0, sout}, 32'd1);
    check("reset_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0; res_valid = 1'b0; err_valid = 1'b0;
    step();

    send(1'b0, 1'b1, 32'd0, 4'd0, 6'b010010, 12);
    check("err_frame_bits", {21'd0, tr[0], tr[1], tr_byte(0), tr[10]}, {21'd0, 11'b0_1_10100101_1});
    check("err_ready_low", low_count(), 11);
    check("err_idle_after", {31'd0, tr[11]}, 32'd1);

    send(1'b0, 1'b1, 32'd0, 4'd0, 6'b100100, 12);
    check("err_c9_payload", {24'd0, tr_byte(0)}, 32'hC9);

    send(1'b1, 1'b0, 32'd0, 4'b0010, 6'd0, 56);
    for (int k = 0; k < 4; k++) check("res0_data_byte", {24'd0, tr_byte(11*k)}, 32'h00);
    check("res0_data_cmd", {31'd0, tr[1]}, 32'd0);
    check("res0_ctl_cmd", {31'd0, tr[45]}, 32'd1);
    check("res0_ctl_payload", {24'd0, tr_byte(44)}, 32'h16);
    check("res0_ready_low", low_count(), 55);

    send(1'b1, 1'b1, 32'h1234_5678, 4'hF, 6'b000001, 20);
    check("collision_ready_low", low_count(), 11);
    check("collision_ctl", {31'd0, tr[1]}, 32'd1);
    check("collision_payload", {24'd0, tr_byte(0)}, {24'd0, err_byte(6'b000001)});

    send(1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0101, 6'd0, 20);
    rst = 1'b1;
    step();
    check("midreset_sout", {31'd0, sout}, 32'd1);
    check("midreset_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    step();
    send(1'b1, 1'b0, 32'hCAFE_0001, 4'b1100, 6'd0, 57);
    check("after_reset_ready_low", low_count(), 55);
    check("after_reset_ctl", {24'd0, tr_byte(44)}, {24'd0, ctl_byte(32'hCAFE_0001, 4'b1100)});

    res_valid = 1'b1; res_data = 32'hFFFF_FFFF; res_flags = 4'b1001;
    tr.delete(); tr_rdy.delete();
    repeat (111) step();
    res_valid = 1'b0;
    check("b2b_gap_sout", {31'd0, tr[55]}, 32'd1);
    check("b2b_gap_ready", {31'd0, tr_rdy[55]}, 32'd1);
    check("b2b_second_start", {31'd0, tr[56]}, 32'd0);
    check("b2b_ready_low", low_count(), 110);
    check("b2b_ctl1", {24'd0, tr_byte(44)}, {24'd0, ctl_byte(32'hFFFF_FFFF, 4'b1001)});
    check("b2b_ctl2", {24'd0, tr_byte(100)}, {24'd0, ctl_byte(32'hFFFF_FFFF, 4'b1001)});
    repeat (60) step();

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      res_valid = ($urandom_range(0, 3) == 0);
      err_valid = ($urandom_range(0, 9) == 0);
      res_data  = $urandom;
      res_flags = 4'($urandom);
      err_flags = 6'($urandom);
      step();
    end
    rst = 1'b0; res_valid = 1'b0; err_valid = 1'b0;
    repeat (60) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mtm_alu_serializer.md
MTM_ALU_SERIALIZER -- requirements
Module: mtm_Alu_serializer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: res_valid  in  1  ALU result request.
REQ-004 SHALL have ports: res_data  in  32  result C.
REQ-005 SHALL have ports: res_flags  in  4  {carry, overflow, zero, negative}.
REQ-006 SHALL have ports: err_valid  in  1  error response request.
REQ-007 SHALL have ports: err_flags  in  6  {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}.
REQ-008 SHALL have ports: in_ready  out  1  high only in IDLE; a request is accepted on (res_valid|err_valid) & in_ready.
REQ-009 SHALL have ports: sout  out  1  registered serial output, idle high.
REQ-010 SHALL have parameter: none; all widths and constants are fixed.

Function
REQ-011 Frame SHALL be 11 bits: start 0, cmd bit (0 data, 1 ctl), 8 payload bits MSB first, stop 1; one bit per clk.
REQ-012 Result packet SHALL be 5 back-to-back data/ctl frames (55 cycles): C[31:24], C[23:16], C[15:8], C[7:0] as data frames, then CTL frame.
REQ-013 Result CTL SHALL be {1'b0, res_flags, crc3}; crc3 uses x^3+x+1, init 000, serial MSB-first over 37 bits {C, 1'b0, res_flags}.
REQ-014 Error packet SHALL be one ctl frame (11 cycles), payload {1'b1, err_flags, parity}; parity makes the byte's ones-count even.
REQ-015 Simultaneous res_valid and err_valid at acceptance SHALL send only the error packet; the result is dropped.
REQ-016 Inputs SHALL be captured on the accept edge; later input changes SHALL NOT affect the packet in flight.
REQ-017 Latency: the start bit SHALL appear on sout in the cycle after the accept edge.
REQ-018 FSM states SHALL be IDLE, START, CMD, DATA, STOP.
REQ-019 IDLE->START on accept; START->CMD; CMD->DATA; DATA->STOP after bit counter reaches 7; STOP->START while frames remain, else STOP->IDLE.
REQ-020 Bit counter SHALL count 0..7; frame counter SHALL count 0..4 (result) or 0..0 (error); neither SHALL wrap mid-packet.
REQ-021 in_ready SHALL be low from the accept edge through the last stop bit, giving at least one idle-high cycle between packets.
REQ-022 Requests arriving while in_ready is low SHALL be ignored, not queued.

Reset
REQ-023 rst high SHALL force, at the next edge: state IDLE, sout 1, in_ready 1, counters 0, captured data 0.
REQ-024 Reset mid-packet SHALL abort the packet with no further frame bits; sout is 1 from the next edge.
REQ-025 A request presented in the same cycle as rst SHALL NOT be accepted.

Structure
REQ-026 Package mtm_Alu_pkg SHALL hold the state enum, CMD_DATA/CMD_CTL bit values, frame length 11, error-flag bit positions, and CRC3 polynomial constant.
REQ-027 CRC3 SHALL be a combinational sub-module mtm_Alu_crc3 (37-bit in, 3-bit out), instantiated once on the captured data.

Verification
REQ-028 Error packet: err_valid, err_flags=6'b010010 -> sout 0,1,10100101,1 (payload 0xA5); in_ready low 11 cycles.
REQ-029 Error packet: err_flags=6'b100100 -> payload 0xC9.
REQ-030 Result packet: res_data=0, res_flags=4'b0010 -> four 0x00 data frames, then ctl payload 0x16 (crc 110); 55 cycles total.
REQ-031 Collision: res_valid and err_valid in the same cycle -> exactly one 11-bit error frame, no data frames.
REQ-032 Reset at cycle 20 of a result packet -> sout=1 and in_ready=1 at the next edge; the next request produces a clean packet.
REQ-033 Back-to-back: res_valid held with res_data=0xFFFFFFFF -> two complete 55-bit packets separated by exactly one idle-high cycle; CTL checked against a CRC3 reference model.
